env_adsr: RTL and testbench
===========================

Name: env_adsr

Overview:
- Per-voice ADSR amplitude envelope. Sits between each oscillator voice output and the modulation/mix stage (downstream of the voice, upstream of the mixer).
- Scales the voice's unsigned offset-binary waveform about midscale by an envelope level.
- The level is driven by a gate and four parameters loaded from the SPI command decoder.
- Advances on a sample-rate tick, so it tracks the divided oscillator clock while running on the system clock.

Parameters:
- WAVE_W, 12, waveform sample width (unsigned offset-binary, midscale = 2^(WAVE_W-1)).
- ENV_W, 8, envelope level width; ENV_MAX = 2^ENV_W-1.
- RATE_W, 8, width of attack/decay/release rate prescaler values.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- sample_en  in  1  one-cycle sample tick; envelope and output update only on this.
- gate  in  1  note gate (level, sampled on clk).
- attack_rate  in  RATE_W  ticks per +1 step in ATTACK, minus 1.
- decay_rate  in  RATE_W  ticks per -1 step in DECAY, minus 1.
- sustain_lvl  in  ENV_W  sustain level.
- release_rate  in  RATE_W  ticks per -1 step in RELEASE, minus 1.
- wave_in  in  WAVE_W  voice waveform.
- wave_out  out  WAVE_W  enveloped waveform, registered.
- env_level  out  ENV_W  current envelope level, registered.
- env_state  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- active  out  1  high when env_state != IDLE.

Behaviour:
- Reset (rst_n low at clk edge): state IDLE, env_level 0, prescaler 0, gate history 0, wave_out = midscale (0x800 at defaults), active 0.
- Gate edges: gate is registered once on clk and edges are detected against that register. Rise and fall events are evaluated on every clk, not gated by sample_en.
- Rise in any state → ATTACK, keeping the current env_level (retrigger from present level, no reset to 0). Prescaler cleared.
- Fall in ATTACK, DECAY or SUSTAIN → RELEASE. Prescaler cleared.
- A gate edge has priority over a prescaler step in the same cycle; that step is discarded.
- Prescaler: on sample_en, if prescaler == current state's rate, step env_level and clear prescaler; else increment prescaler. Rate 0 steps every tick. Prescaler also clears on every state change.
- ATTACK: step +1. When a step reaches ENV_MAX → DECAY. If entered at ENV_MAX, go to DECAY on the next sample_en.
- DECAY: on sample_en, if env_level <= sustain_lvl → SUSTAIN with env_level := sustain_lvl. Otherwise step -1.
- SUSTAIN: env_level := sustain_lvl on each sample_en (live tracking of register writes). Stays until gate falls.
- RELEASE: step -1. When env_level reaches 0 → IDLE. Entering RELEASE at 0 → IDLE on the next sample_en.
- IDLE: env_level held at 0; only a gate rise leaves it.
- env_level saturates: never wraps past ENV_MAX or below 0.
- Output arithmetic (on sample_en, registered, 1 clk latency):
  - s = wave_in - midscale, signed WAVE_W+1.
  - p = s * env_level, signed.
  - wave_out = midscale + (p >>> ENV_W), arithmetic shift, truncated to WAVE_W.
  - Full scale is ENV_MAX/2^ENV_W (255/256); no overflow possible.
  - env_level 0 gives exactly midscale.
  - The output uses the env_level value before that tick's update.
- Between sample_en ticks, wave_out, env_level and the prescaler hold their values. State may still change on a gate edge.
- Rate or sustain inputs changing mid-phase take effect at the next prescaler compare; no glitch or restart.
- env_state and active are registered and consistent with env_level in the same cycle.

Test Plan:
- Reset, then sample_en every cycle, gate=0, wave_in=0xFFF → wave_out=0x800, env_level=0, env_state=0, active=0 for 20 ticks.
- attack_rate=0, decay_rate=1, sustain_lvl=0x80, gate=1 → env reaches 0xFF after 255 ticks, state=DECAY. It then reaches 0x80 in 254 ticks (one step per 2 ticks, 127 steps), then state=SUSTAIN.
- In SUSTAIN at 0x80, wave_in=0xFFF → wave_out = 0x800 + ((0x7FF*0x80)>>>8) = 0xBFF. wave_in=0x000 → 0x400.
- gate falls at env=0x80 with release_rate=3 → RELEASE, one step per 4 ticks; reaches 0 after 512 ticks, then IDLE, active=0.
- Retrigger: gate low→high while RELEASE at env=0x40 → ATTACK from 0x40 without dipping. A gate edge and a step due in the same cycle → the step is discarded and the prescaler is 0 next cycle.
- Reset mid-ATTACK at env=0x30 → next cycle env_level=0, IDLE, wave_out=0x800. sustain_lvl=0xFF → DECAY goes straight to SUSTAIN at 0xFF.

Source files
------------

// File: rtl/env_adsr.sv
// Per-voice ADSR envelope: scales an offset-binary voice sample about midscale by an envelope level.
// Latency: wave_out and env_level update one clk after the sample_en tick; gate edges act on every clk.
// Backpressure: none; sample_en paces the envelope, and the block accepts every tick.
module env_adsr #(
  parameter int WAVE_W = 12,
  parameter int ENV_W  = 8,
  parameter int RATE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic              gate,
  input  logic [RATE_W-1:0] attack_rate,
  input  logic [RATE_W-1:0] decay_rate,
  input  logic [ENV_W-1:0]  sustain_lvl,
  input  logic [RATE_W-1:0] release_rate,
  input  logic [WAVE_W-1:0] wave_in,
  output logic [WAVE_W-1:0] wave_out,
  output logic [ENV_W-1:0]  env_level,
  output logic [2:0]        env_state,
  output logic              active
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  localparam int PW = WAVE_W + ENV_W + 2;
  localparam logic [WAVE_W-1:0] MID     = {1'b1, {(WAVE_W-1){1'b0}}};
  localparam logic [ENV_W-1:0]  ENV_MAX = {ENV_W{1'b1}};
  localparam logic [ENV_W-1:0]  ENV_TOP = ENV_MAX - 1'b1;
  localparam logic [ENV_W-1:0]  ENV_ONE = {{(ENV_W-1){1'b0}}, 1'b1};

  state_t              state;
  logic [RATE_W-1:0]   presc;
  logic                gate_q;
  logic                gate_rise;
  logic                gate_fall;
  logic                gated_phase;
  logic [RATE_W-1:0]   rate_sel;
  logic                step_due;
  logic signed [PW-1:0] s_ext;
  logic signed [PW-1:0] e_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;
  logic [WAVE_W-1:0]   wave_nxt;

  assign env_state   = state;
  assign gate_rise   = gate & ~gate_q;
  assign gate_fall   = ~gate & gate_q;
  assign gated_phase = (state == S_ATTACK) || (state == S_DECAY) || (state == S_SUSTAIN);

  // Select the prescaler terminal count for the phase currently running.
  always_comb begin
    rate_sel = '0;
    case (state)
      S_ATTACK:  rate_sel = attack_rate;
      S_DECAY:   rate_sel = decay_rate;
      S_RELEASE: rate_sel = release_rate;
      default:   rate_sel = '0;
    endcase
    step_due = (presc == rate_sel);
  end

  // Signed scaling about midscale using the pre-update envelope level; range cannot overflow PW bits.
  always_comb begin
    s_ext    = $signed({{(ENV_W+2){1'b0}}, wave_in}) - $signed({{(ENV_W+2){1'b0}}, MID});
    e_ext    = $signed({{(WAVE_W+2){1'b0}}, env_level});
    prod     = s_ext * e_ext;
    shifted  = prod >>> ENV_W;
    wave_nxt = MID + shifted[WAVE_W-1:0];
  end

  // Envelope FSM: gate edges every clk (and win over a same-cycle step), level stepping on sample_en.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      env_level <= '0;
      presc     <= '0;
      gate_q    <= 1'b0;
      wave_out  <= MID;
      active    <= 1'b0;
    end else begin
      gate_q <= gate;
      if (sample_en) begin
        wave_out <= wave_nxt;
      end
      if (gate_rise) begin
        // Retrigger keeps the present level so there is no click back to zero.
        state  <= S_ATTACK;
        active <= 1'b1;
        presc  <= '0;
      end else if (gate_fall && gated_phase) begin
        state <= S_RELEASE;
        presc <= '0;
      end else if (sample_en) begin
        case (state)
          S_IDLE: begin
            env_level <= '0;
            presc     <= '0;
          end
          S_ATTACK: begin
            if (env_level == ENV_MAX) begin
              state <= S_DECAY;
              presc <= '0;
            end else if (step_due) begin
              env_level <= env_level + ENV_ONE;
              presc     <= '0;
              if (env_level == ENV_TOP) begin
                state <= S_DECAY;
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end
          S_DECAY: begin
            if (env_level <= sustain_lvl) begin
              state     <= S_SUSTAIN;
              env_level <= sustain_lvl;
              presc     <= '0;
            end else if (step_due) begin
              env_level <= env_level - ENV_ONE;
              presc     <= '0;
            end else begin
              presc <= presc + 1'b1;
            end
          end
          S_SUSTAIN: begin
            // Track live sustain writes from the command decoder.
            env_level <= sustain_lvl;
            presc     <= '0;
          end
          S_RELEASE: begin
            if (env_level == '0) begin
              state  <= S_IDLE;
              active <= 1'b0;
              presc  <= '0;
            end else if (step_due) begin
              env_level <= env_level - ENV_ONE;
              presc     <= '0;
              if (env_level == ENV_ONE) begin
                state  <= S_IDLE;
                active <= 1'b0;
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end
          default: begin
            state     <= S_IDLE;
            active    <= 1'b0;
            env_level <= '0;
            presc     <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_env_adsr.sv
// Bench for env_adsr: phase timing, output scaling table, retrigger and reset corners.
// Inputs driven and outputs sampled 1ns after the rising clk edge.
// Expected wave_out values are queued when a tick is driven and popped after it lands.
module tb_env_adsr;

  logic        clk;
  logic        rst_n;
  logic        sample_en;
  logic        gate;
  logic [7:0]  attack_rate;
  logic [7:0]  decay_rate;
  logic [7:0]  sustain_lvl;
  logic [7:0]  release_rate;
  logic [11:0] wave_in;
  logic [11:0] wave_out;
  logic [7:0]  env_level;
  logic [2:0]  env_state;
  logic        active;

  int n_cmp;
  int n_bad;
  int exp_q[$];

  typedef struct {
    logic [7:0]  lvl;
    logic [11:0] win;
    int          hand_exp;
  } vec_t;

  vec_t vecs[10];

  env_adsr #(.WAVE_W(12), .ENV_W(8), .RATE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .gate(gate),
    .attack_rate(attack_rate), .decay_rate(decay_rate), .sustain_lvl(sustain_lvl),
    .release_rate(release_rate), .wave_in(wave_in), .wave_out(wave_out),
    .env_level(env_level), .env_state(env_state), .active(active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_env(input string name, input int lvl, input int st, input int act_exp);
    chk({name, " env_level"}, int'(env_level), lvl);
    chk({name, " env_state"}, int'(env_state), st);
    chk({name, " active"}, int'(active), act_exp);
  endtask

  // Independent reference for the output scaling: midscale + floor((w-mid)*e / 256).
  function automatic int model_out(input int w, input int e);
    int p;
    p = (w - 2048) * e;
    return (2048 + (p >>> 8)) & 12'hFFF;
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    vecs[0] = '{8'h80, 12'hFFF, 12'hBFF};
    vecs[1] = '{8'h80, 12'h000, 12'h400};
    vecs[2] = '{8'hFF, 12'hFFF, -1};
    vecs[3] = '{8'hFF, 12'h000, -1};
    vecs[4] = '{8'h01, 12'h000, 12'h7F8};
    vecs[5] = '{8'h01, 12'h7FF, 12'h7FF};
    vecs[6] = '{8'h55, 12'h123, -1};
    vecs[7] = '{8'hC3, 12'hABC, -1};
    vecs[8] = '{8'h00, 12'hFFF, 12'h800};
    vecs[9] = '{8'h40, 12'h801, 12'h800};

    // Reset with ticks running.
    rst_n = 1'b0; sample_en = 1'b1; gate = 1'b0; wave_in = 12'hFFF;
    attack_rate = 8'd0; decay_rate = 8'd1; sustain_lvl = 8'h80; release_rate = 8'd3;
    cyc(2);
    chk("reset wave_out", int'(wave_out), 12'h800);
    chk_env("reset", 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("idle wave_out", int'(wave_out), 12'h800);
      chk("idle env_level", int'(env_level), 0);
      chk("idle active", int'(active), 0);
    end

    // Attack at rate 0, decay one step per two ticks down to sustain.
    gate = 1'b1;
    cyc(1);
    chk_env("rise", 0, 1, 1);
    cyc(254);
    chk_env("attack 254", 8'hFE, 1, 1);
    cyc(1);
    chk_env("attack top", 8'hFF, 2, 1);
    cyc(254);
    chk_env("decay end", 8'h80, 2, 1);
    cyc(1);
    chk_env("sustain entry", 8'h80, 3, 1);

    // Output scaling table, driven through live sustain tracking.
    foreach (vecs[k]) begin
      sustain_lvl = vecs[k].lvl;
      wave_in = vecs[k].win;
      cyc(1);
      if (vecs[k].hand_exp >= 0) exp_q.push_back(vecs[k].hand_exp);
      else exp_q.push_back(model_out(int'(vecs[k].win), int'(vecs[k].lvl)));
      cyc(1);
      chk("table env_level", int'(env_level), int'(vecs[k].lvl));
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scoreboard: queue empty");
      end else begin
        chk("table wave_out", int'(wave_out), exp_q.pop_front());
      end
    end

    // Holding between ticks: nothing moves without sample_en.
    sample_en = 1'b0;
    sustain_lvl = 8'h80;
    wave_in = 12'hFFF;
    cyc(3);
    chk("hold env_level", int'(env_level), 8'h40);
    chk("hold wave_out", int'(wave_out), 12'h800);
    sample_en = 1'b1;
    cyc(1);
    chk("resume env_level", int'(env_level), 8'h80);

    // Release at rate 3 from 0x80: 512 ticks to zero.
    gate = 1'b0;
    cyc(1);
    chk_env("fall", 8'h80, 4, 1);
    cyc(511);
    chk_env("release 511", 1, 4, 1);
    cyc(1);
    chk_env("release done", 0, 0, 0);

    // Build a RELEASE at 0x40, then retrigger exactly when a release step is due.
    attack_rate = 8'd0; decay_rate = 8'd0; sustain_lvl = 8'h40;
    gate = 1'b1;
    cyc(1 + 255 + 191 + 1);
    chk_env("sustain 0x40", 8'h40, 3, 1);
    gate = 1'b0;
    cyc(1);
    cyc(3);
    chk_env("release pre-step", 8'h40, 4, 1);
    attack_rate = 8'd1;
    gate = 1'b1;
    cyc(1);
    chk_env("retrigger", 8'h40, 1, 1);
    cyc(1);
    chk("retrigger presc 1", int'(env_level), 8'h40);
    cyc(1);
    chk("retrigger step", int'(env_level), 8'h41);

    // Reset in the middle of ATTACK.
    gate = 1'b0; attack_rate = 8'd0;
    cyc(1);
    gate = 1'b1;
    cyc(1 + 8'h30 - 8'h41 + 256 - 256);
    rst_n = 1'b0; gate = 1'b0; cyc(1); rst_n = 1'b1;
    gate = 1'b1;
    cyc(1 + 8'h30);
    chk_env("attack 0x30", 8'h30, 1, 1);
    chk("attack wave_out", int'(wave_out), model_out(12'hFFF, 8'h2F));
    rst_n = 1'b0;
    cyc(1);
    chk_env("mid reset", 0, 0, 0);
    chk("mid reset wave_out", int'(wave_out), 12'h800);

    // Sustain at full scale: DECAY goes straight to SUSTAIN.
    gate = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    sustain_lvl = 8'hFF; decay_rate = 8'd1;
    gate = 1'b1;
    cyc(1 + 255);
    chk_env("full attack", 8'hFF, 2, 1);
    cyc(1);
    chk_env("full sustain", 8'hFF, 3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
